rvtu_mem_arb: RTL and testbench
===============================

Name: rvtu_mem_arb

Overview:
- Shares one 32-bit word-addressed memory port (maddr/mrd/mwr/mwdata/mresp/mrdata) between NREQ rvtu requesters, e.g. fetch plus MEM/WB, or several rvtu cores.
- Round-robin arbitration with one outstanding transaction at a time.
- The granted request is latched and driven to memory until mresp; the response is steered back to the granted requester only.
- Sits between the rvtu stages and the memory/cache model.

Parameters:
- NREQ, 2, number of requesters (2..8).
- IDXW, $clog2(NREQ) (min 1), grant index width (derived, not overridable).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_maddr  in  [NREQ-1:0][31:0]  requester word address (bits [1:0] ignored, forced 0 downstream)
- req_mrd  in  [NREQ-1:0]  read request
- req_mwr  in  [NREQ-1:0][3:0]  byte write strobes; nonzero = write request
- req_mwdata  in  [NREQ-1:0][31:0]  write data
- req_mresp  out  [NREQ-1:0]  one-hot completion pulse
- req_mrdata  out  32  read data, broadcast, valid with req_mresp
- maddr  out  32  downstream address
- mrd  out  1  downstream read
- mwr  out  4  downstream write strobes
- mwdata  out  32  downstream write data
- mresp  in  1  downstream completion pulse
- mrdata  in  32  downstream read data
- quiesce  in  1  block new grants
- idle  out  1  no transaction in flight
- gnt_idx  out  IDXW  index of current/last grant (debug)

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst. These are fixed.
- Request predicate: req_i = req_mrd[i] | (|req_mwr[i]).
- Requester protocol:
  - Requester holds its request stable until its req_mresp pulse.
  - Any request seen in a later cycle is a new transaction, including back-to-back.
- FSM has 2 states, IDLE and BUSY.
- IDLE:
  - If ~quiesce and any req_i, select the first requesting index at or after rr_ptr, wrapping modulo NREQ.
  - Latch {addr[31:2],2'b0, rd, wr, wdata} of that requester. Set gnt_idx, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Drive maddr/mwdata from the latch.
  - mrd = latched rd; mwr = latched wr.
  - Requester inputs are ignored.
  - On mresp: req_mresp[gnt_idx]=1 combinationally that cycle, req_mrdata=mrdata, rr_ptr <= (gnt_idx+1) mod NREQ, go to IDLE.
- Read and write both set: illegal. Latch as a read with wr forced to 4'b0.
- Outputs in IDLE: mrd=0, mwr=0, maddr/mwdata hold the last latched value, req_mresp=0, idle=1.
- Timing:
  - Grant to downstream request: 1 cycle.
  - Downstream response to requester: 0 cycles.
  - Minimum turnaround: 1 IDLE cycle between transactions.
- mresp in IDLE is spurious. Ignore it: no req_mresp, no state change.
- quiesce:
  - Sampled only in IDLE.
  - An in-flight BUSY transaction always completes.
  - idle=1 once back in IDLE.
- Wrap: rr_ptr stays in 0..NREQ-1. For non-power-of-2 NREQ, NREQ-1 wraps to 0.
- Reset:
  - State=IDLE, rr_ptr=0, gnt_idx=0, latch cleared to 0.
  - All outputs deasserted, idle=1.
  - A reset mid-BUSY abandons the transaction; its late mresp is treated as spurious.
- req_mrdata is undefined-but-stable (last mrdata) when no req_mresp.

Decomposition:
- rv_pkg additions:
  - memReq_t {addr[31:0], rd, wr[3:0], wdata[31:0]}
  - arbState_t enum {ARB_IDLE, ARB_BUSY}
- One sub-module, rvtu_rr_pick (combinational): inputs req vector and rr_ptr; outputs valid and the selected index.

Test Plan:
- Single read: req0 rd @0x104 held, mresp after 3 cycles with mrdata=0xDEADBEEF -> mrd=1/maddr=0x104 from cycle 1; req_mresp=2'b01 with req_mrdata=0xDEADBEEF in the mresp cycle; mrd=0 next cycle.
- Contention, NREQ=2: both requesters request continuously, 1-cycle mresp -> grants alternate 0,1,0,1; each grant separated by one IDLE cycle; no requester ever gets two consecutive grants.
- Write path: req1 mwr=4'b1100, addr 0x203, wdata 0x11223344 -> maddr=0x200, mwr=4'b1100, mwdata=0x11223344; req_mresp=2'b10 on mresp.
- Illegal rd+wr: req0 mrd=1, mwr=4'hF -> downstream mrd=1, mwr=0.
- Spurious/reset: mresp pulse in IDLE -> no req_mresp; rst asserted mid-BUSY -> next cycle mrd=0, idle=1, rr_ptr=0, and a following mresp is ignored.
- quiesce: quiesce=1 with req0 pending in IDLE -> no grant for 5 cycles; quiesce raised during BUSY -> transaction completes, then idle=1 and no new grant until quiesce=0.

Source files
------------

// File: rtl/rvtu_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rvtu_mem_arb_pkg
// Description : Shared types for the rvtu memory-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rvtu_mem_arb_pkg;

    localparam int unsigned MEM_AW = 32;
    localparam int unsigned MEM_DW = 32;
    localparam int unsigned MEM_SW = 4;

    typedef struct packed {
        logic [MEM_AW-1:0] addr;
        logic              rd;
        logic [MEM_SW-1:0] wr;
        logic [MEM_DW-1:0] wdata;
    } memReq_t;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arbState_t;

endpackage
`default_nettype wire

// File: rtl/rvtu_mem_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : rvtu_mem_arb_if
// Description : Requester-side and memory-side bus of the rvtu memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface rvtu_mem_arb_if #(
    parameter int NREQ = 2
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0][31:0] req_maddr;
    logic [NREQ-1:0]       req_mrd;
    logic [NREQ-1:0][3:0]  req_mwr;
    logic [NREQ-1:0][31:0] req_mwdata;
    logic [NREQ-1:0]       req_mresp;
    logic [31:0]           req_mrdata;

    logic [31:0]           maddr;
    logic                  mrd;
    logic [3:0]            mwr;
    logic [31:0]           mwdata;
    logic                  mresp;
    logic [31:0]           mrdata;

    logic                  quiesce;
    logic                  idle;
    logic [IDXW-1:0]       gnt_idx;

    // Arbiter view
    modport slave (
        input  req_maddr, req_mrd, req_mwr, req_mwdata, mresp, mrdata, quiesce,
        output req_mresp, req_mrdata, maddr, mrd, mwr, mwdata, idle, gnt_idx
    );

    // Environment view: requesters plus memory model
    modport master (
        output req_maddr, req_mrd, req_mwr, req_mwdata, mresp, mrdata, quiesce,
        input  req_mresp, req_mrdata, maddr, mrd, mwr, mwdata, idle, gnt_idx
    );

endinterface
`default_nettype wire

// File: rtl/rvtu_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rvtu_rr_pick
// Description : Combinational round-robin picker: first request at/after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rvtu_rr_pick #(
    parameter int NREQ = 2
) (
    input  wire logic [NREQ-1:0]                          req_i,
    input  wire logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] ptr_i,
    output logic                                          valid_o,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0]    idx_o
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDXW-1:0] w_cand;

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        w_cand  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_cand = IDXW'((int'(ptr_i) + k) % NREQ);
            if (req_i[w_cand]) begin
                idx_o = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rvtu_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : rvtu_mem_arb
// Description : Round-robin arbiter sharing one memory port among NREQ rvtu
//               requesters, one outstanding transaction at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module rvtu_mem_arb #(
    parameter int NREQ = 2
) (
    input  wire logic     clk,
    input  wire logic     rst,
    rvtu_mem_arb_if.slave bus
);
    import rvtu_mem_arb_pkg::*;

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arbState_t       state_q, state_d;
    memReq_t         latch_q, latch_d;
    logic [IDXW-1:0] gnt_q,   gnt_d;
    logic [IDXW-1:0] ptr_q,   ptr_d;
    logic [31:0]     rdata_q, rdata_d;

    logic [NREQ-1:0] w_req;
    logic            w_pick_valid;
    logic [IDXW-1:0] w_pick_idx;
    logic [NREQ-1:0] w_resp;
    logic            w_done;

    for (genvar i = 0; i < NREQ; i++) begin : g_req
        assign w_req[i] = bus.req_mrd[i] | (|bus.req_mwr[i]);
    end

    rvtu_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req_i   (w_req),
        .ptr_i   (ptr_q),
        .valid_o (w_pick_valid),
        .idx_o   (w_pick_idx)
    );

    assign w_done = (state_q == ARB_BUSY) && bus.mresp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            latch_q <= '0;
            gnt_q   <= '0;
            ptr_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            latch_q <= latch_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        latch_d = latch_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        rdata_d = rdata_q;
        w_resp  = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (!bus.quiesce && w_pick_valid) begin
                    latch_d.addr  = {bus.req_maddr[w_pick_idx][31:2], 2'b00};
                    latch_d.rd    = bus.req_mrd[w_pick_idx];
                    // A combined read+write is demoted to a plain read.
                    latch_d.wr    = bus.req_mrd[w_pick_idx] ? 4'b0000
                                                            : bus.req_mwr[w_pick_idx];
                    latch_d.wdata = bus.req_mwdata[w_pick_idx];
                    gnt_d         = w_pick_idx;
                    state_d       = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (bus.mresp) begin
                    w_resp[gnt_q] = 1'b1;
                    rdata_d       = bus.mrdata;
                    ptr_d         = (gnt_q == IDXW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
                    state_d       = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign bus.maddr      = latch_q.addr;
    assign bus.mwdata     = latch_q.wdata;
    assign bus.mrd        = (state_q == ARB_BUSY) & latch_q.rd;
    assign bus.mwr        = (state_q == ARB_BUSY) ? latch_q.wr : 4'b0000;
    assign bus.req_mresp  = w_resp;
    assign bus.req_mrdata = w_done ? bus.mrdata : rdata_q;
    assign bus.idle       = (state_q == ARB_IDLE);
    assign bus.gnt_idx    = gnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rvtu_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_rvtu_mem_arb
// Description : Directed self-checking bench for rvtu_mem_arb with NREQ=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rvtu_mem_arb;

    localparam int NREQ = 2;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    rvtu_mem_arb_if #(.NREQ(NREQ)) bus ();

    rvtu_mem_arb #(.NREQ(NREQ)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_reqs();
        bus.req_maddr  = '0;
        bus.req_mrd    = '0;
        bus.req_mwr    = '0;
        bus.req_mwdata = '0;
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst         = 1'b1;
        bus.mresp   = 1'b0;
        bus.mrdata  = '0;
        bus.quiesce = 1'b0;
        clear_reqs();
        step();
        step();
        rst = 1'b0;
        #1;
        check_eq("rst_idle",  32'(bus.idle), 32'h1);
        check_eq("rst_mrd",   32'(bus.mrd), 32'h0);
        check_eq("rst_mwr",   32'(bus.mwr), 32'h0);
        check_eq("rst_resp",  32'(bus.req_mresp), 32'h0);
        check_eq("rst_maddr", bus.maddr, 32'h0);
        check_eq("rst_gnt",   32'(bus.gnt_idx), 32'h0);

        // Single read from requester 0, response after three BUSY cycles
        step();
        bus.req_mrd[0]   = 1'b1;
        bus.req_maddr[0] = 32'h0000_0104;
        #1;
        check_eq("rd_pre_mrd", 32'(bus.mrd), 32'h0);
        step();
        #1;
        check_eq("rd_c1_mrd",   32'(bus.mrd), 32'h1);
        check_eq("rd_c1_maddr", bus.maddr, 32'h0000_0104);
        check_eq("rd_c1_idle",  32'(bus.idle), 32'h0);
        check_eq("rd_c1_resp",  32'(bus.req_mresp), 32'h0);
        step();
        step();
        bus.mresp  = 1'b1;
        bus.mrdata = 32'hDEAD_BEEF;
        #1;
        check_eq("rd_resp",  32'(bus.req_mresp), 32'h1);
        check_eq("rd_rdata", bus.req_mrdata, 32'hDEAD_BEEF);
        step();
        bus.mresp = 1'b0;
        clear_reqs();
        #1;
        check_eq("rd_post_mrd",   32'(bus.mrd), 32'h0);
        check_eq("rd_post_idle",  32'(bus.idle), 32'h1);
        check_eq("rd_post_resp",  32'(bus.req_mresp), 32'h0);
        check_eq("rd_post_rdata", bus.req_mrdata, 32'hDEAD_BEEF);

        // Contention from reset: grants must alternate 0,1,0,1
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req_mrd      = 2'b11;
        bus.req_maddr[0] = 32'h0000_0010;
        bus.req_maddr[1] = 32'h0000_0020;
        #1;
        check_eq("ct_idle0", 32'(bus.idle), 32'h1);
        for (int g = 0; g < 4; g++) begin
            step();
            bus.mresp  = 1'b1;
            bus.mrdata = 32'h100 + 32'(g);
            #1;
            check_eq("ct_gnt",   32'(bus.gnt_idx), 32'(g % 2));
            check_eq("ct_maddr", bus.maddr, (g % 2 == 0) ? 32'h10 : 32'h20);
            check_eq("ct_resp",  32'(bus.req_mresp), (g % 2 == 0) ? 32'h1 : 32'h2);
            check_eq("ct_rdata", bus.req_mrdata, 32'h100 + 32'(g));
            step();
            bus.mresp = 1'b0;
            if (g == 3) clear_reqs();
            #1;
            check_eq("ct_gap_idle", 32'(bus.idle), 32'h1);
            check_eq("ct_gap_resp", 32'(bus.req_mresp), 32'h0);
        end
        step();
        #1;
        check_eq("ct_end_idle", 32'(bus.idle), 32'h1);

        // Write from requester 1 with an unaligned address
        bus.req_mwr[1]    = 4'b1100;
        bus.req_maddr[1]  = 32'h0000_0203;
        bus.req_mwdata[1] = 32'h1122_3344;
        step();
        #1;
        check_eq("wr_maddr",  bus.maddr, 32'h0000_0200);
        check_eq("wr_mwr",    32'(bus.mwr), 32'hC);
        check_eq("wr_mwdata", bus.mwdata, 32'h1122_3344);
        check_eq("wr_mrd",    32'(bus.mrd), 32'h0);
        check_eq("wr_gnt",    32'(bus.gnt_idx), 32'h1);
        bus.mresp = 1'b1;
        #1;
        check_eq("wr_resp", 32'(bus.req_mresp), 32'h2);
        step();
        bus.mresp = 1'b0;
        clear_reqs();

        // Read and write together is treated as a read
        bus.req_mrd[0]   = 1'b1;
        bus.req_mwr[0]   = 4'hF;
        bus.req_maddr[0] = 32'h0000_0040;
        step();
        #1;
        check_eq("il_mrd", 32'(bus.mrd), 32'h1);
        check_eq("il_mwr", 32'(bus.mwr), 32'h0);
        bus.mresp = 1'b1;
        #1;
        check_eq("il_resp", 32'(bus.req_mresp), 32'h1);
        step();
        bus.mresp = 1'b0;
        clear_reqs();

        // Spurious response while idle
        bus.mresp = 1'b1;
        #1;
        check_eq("sp_resp", 32'(bus.req_mresp), 32'h0);
        step();
        bus.mresp = 1'b0;
        #1;
        check_eq("sp_idle", 32'(bus.idle), 32'h1);

        // Reset in the middle of a transaction
        bus.req_mrd[1]   = 1'b1;
        bus.req_maddr[1] = 32'h0000_0080;
        step();
        #1;
        check_eq("rb_mrd", 32'(bus.mrd), 32'h1);
        rst = 1'b1;
        clear_reqs();
        step();
        rst = 1'b0;
        #1;
        check_eq("rb_mrd0", 32'(bus.mrd), 32'h0);
        check_eq("rb_idle", 32'(bus.idle), 32'h1);
        check_eq("rb_gnt",  32'(bus.gnt_idx), 32'h0);
        bus.mresp = 1'b1;
        #1;
        check_eq("rb_late_resp", 32'(bus.req_mresp), 32'h0);
        step();
        bus.mresp        = 1'b0;
        bus.req_mrd      = 2'b11;
        bus.req_maddr[0] = 32'h0000_0300;
        bus.req_maddr[1] = 32'h0000_0400;
        #1;
        check_eq("rb_late_idle", 32'(bus.idle), 32'h1);
        step();
        #1;
        check_eq("rb_ptr_gnt", 32'(bus.gnt_idx), 32'h0);
        check_eq("rb_ptr_adr", bus.maddr, 32'h0000_0300);
        bus.mresp = 1'b1;
        #1;
        check_eq("rb_ptr_resp", 32'(bus.req_mresp), 32'h1);
        step();
        bus.mresp = 1'b0;
        clear_reqs();

        // quiesce blocks grants while idle
        bus.quiesce      = 1'b1;
        bus.req_mrd[0]   = 1'b1;
        bus.req_maddr[0] = 32'h0000_0500;
        for (int c = 0; c < 5; c++) begin
            step();
            #1;
            check_eq("qs_idle", 32'(bus.idle), 32'h1);
            check_eq("qs_mrd",  32'(bus.mrd), 32'h0);
        end
        bus.quiesce = 1'b0;
        step();
        #1;
        check_eq("qs_go_mrd", 32'(bus.mrd), 32'h1);
        check_eq("qs_go_gnt", 32'(bus.gnt_idx), 32'h0);

        // quiesce raised mid-transaction lets it finish
        bus.quiesce = 1'b1;
        step();
        #1;
        check_eq("qb_busy_mrd", 32'(bus.mrd), 32'h1);
        bus.mresp = 1'b1;
        #1;
        check_eq("qb_resp", 32'(bus.req_mresp), 32'h1);
        step();
        bus.mresp = 1'b0;
        #1;
        check_eq("qb_idle1", 32'(bus.idle), 32'h1);
        step();
        #1;
        check_eq("qb_idle2", 32'(bus.idle), 32'h1);
        check_eq("qb_mrd2",  32'(bus.mrd), 32'h0);
        bus.quiesce = 1'b0;
        step();
        #1;
        check_eq("qb_regrant", 32'(bus.mrd), 32'h1);
        bus.mresp = 1'b1;
        #1;
        check_eq("qb_regrant_resp", 32'(bus.req_mresp), 32'h1);
        step();
        bus.mresp = 1'b0;
        clear_reqs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
